dec_entry_accum: RTL and testbench



---
 rtl/dec_entry_pkg.sv | 39 +++
 rtl/seg7_digit.sv | 19 +
 rtl/dec_entry_accum.sv | 160 ++++++++++++++++
 tb/tb_dec_entry_accum.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dec_entry_pkg.sv
// Shared types and constants for the decimal-entry accumulator.
// FSM state encoding, accumulator width and the 7-segment digit table.
package dec_entry_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MUL8,
        ADD2,
        ADDD
    } state_t;

    localparam int ACC_W = 14;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low gfedcba patterns, digit 0 in the lowest slot.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0010000,
        7'b0000000,
        7'b1111000,
        7'b0000010,
        7'b0010010,
        7'b0011001,
        7'b0110000,
        7'b0100100,
        7'b1111001,
        7'b1000000
    };

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        s = SEG_BLANK;
        if (d <= 4'd9) begin
            s = SEG_TABLE[d];
        end
        return s;
    endfunction

endpackage

// File: rtl/seg7_digit.sv
// Single-digit active-low 7-segment encoder with a blanking input.
// Out-of-range digit codes render blank.
module seg7_digit
    import dec_entry_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    // Blank overrides the digit lookup.
    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            seg = seg_of(digit);
        end
    end

endmodule

// File: rtl/dec_entry_accum.sv
// Decimal keypad-style entry: accumulates up to MAX_DIGITS digits as acc*10+d.
// Optional HEX echo of entered digits under DEC_ENTRY_ECHO_EN.
module dec_entry_accum
    import dec_entry_pkg::*;
#(
    parameter int MAX_DIGITS = 4,
    parameter int OUT_W      = 10
) (
    input  logic             CLOCK_50,
    input  logic             RST_N,
    input  logic [3:0]       SW,
    input  logic             KEY_ENTER_N,
    input  logic             KEY_CLEAR_N,
    output logic [OUT_W-1:0] VALUE,
    output logic             OVF,
    output logic             ERR,
    output logic             FULL,
    output logic             BUSY
`ifdef DEC_ENTRY_ECHO_EN
    ,
    output logic [6:0]       HEX3,
    output logic [6:0]       HEX2,
    output logic [6:0]       HEX1,
    output logic [6:0]       HEX0
`endif
);

    localparam logic [2:0] CNT_MAX = 3'(MAX_DIGITS);

    logic ent_s1, ent_s2, ent_d;
    logic clr_s1, clr_s2, clr_d;
    logic enter_p, clear_p;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] tmp;
    logic [3:0]       dig_reg;
    logic [2:0]       cnt;
    logic             err;

`ifdef DEC_ENTRY_ECHO_EN
    localparam int NB = (MAX_DIGITS > 4) ? MAX_DIGITS : 4;
    logic [NB-1:0][3:0] bcd;
`endif

    // Synchronise both buttons and turn each press into a 1-cycle pulse.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            ent_s1  <= 1'b1;
            ent_s2  <= 1'b1;
            ent_d   <= 1'b1;
            clr_s1  <= 1'b1;
            clr_s2  <= 1'b1;
            clr_d   <= 1'b1;
            enter_p <= 1'b0;
            clear_p <= 1'b0;
        end else begin
            ent_s1  <= KEY_ENTER_N;
            ent_s2  <= ent_s1;
            ent_d   <= ent_s2;
            clr_s1  <= KEY_CLEAR_N;
            clr_s2  <= clr_s1;
            clr_d   <= clr_s2;
            enter_p <= ent_d & ~ent_s2;
            clear_p <= clr_d & ~clr_s2;
        end
    end

    // Shift-and-add conversion: acc = acc*8 + acc*2 + digit over three steps.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            acc     <= '0;
            tmp     <= '0;
            dig_reg <= '0;
            cnt     <= '0;
            err     <= 1'b0;
`ifdef DEC_ENTRY_ECHO_EN
            bcd     <= '0;
`endif
        end else if (clear_p) begin
            state <= IDLE;
            acc   <= '0;
            tmp   <= '0;
            cnt   <= '0;
            err   <= 1'b0;
`ifdef DEC_ENTRY_ECHO_EN
            bcd   <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (enter_p) begin
                        if (SW > 4'd9) begin
                            err <= 1'b1;
                        end else if (cnt != CNT_MAX) begin
                            dig_reg <= SW;
                            tmp     <= {acc[ACC_W-4:0], 3'b000};
                            state   <= MUL8;
                        end
                    end
                end
                MUL8: begin
                    tmp   <= tmp + {acc[ACC_W-2:0], 1'b0};
                    state <= ADD2;
                end
                ADD2: begin
                    acc   <= tmp + {{(ACC_W-4){1'b0}}, dig_reg};
                    cnt   <= cnt + 3'd1;
`ifdef DEC_ENTRY_ECHO_EN
                    bcd   <= {bcd[NB-2:0], dig_reg};
`endif
                    state <= ADDD;
                end
                ADDD: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Status outputs decode directly from registered state.
    always_comb begin
        VALUE = acc[OUT_W-1:0];
        OVF   = (acc >> OUT_W) != '0;
        ERR   = err;
        FULL  = (cnt == CNT_MAX);
        BUSY  = (state != IDLE);
    end

`ifdef DEC_ENTRY_ECHO_EN
    seg7_digit u_hex0 (
        .digit (bcd[0]),
        .blank (cnt <= 3'd0),
        .seg   (HEX0)
    );

    seg7_digit u_hex1 (
        .digit (bcd[1]),
        .blank (cnt <= 3'd1),
        .seg   (HEX1)
    );

    seg7_digit u_hex2 (
        .digit (bcd[2]),
        .blank (cnt <= 3'd2),
        .seg   (HEX2)
    );

    seg7_digit u_hex3 (
        .digit (bcd[3]),
        .blank (cnt <= 3'd3),
        .seg   (HEX3)
    );
`endif

endmodule

// File: tb/tb_dec_entry_accum.sv
// Directed testbench for dec_entry_accum.
// Echo checks are included when DEC_ENTRY_ECHO_EN is defined.
module tb_dec_entry_accum;

    logic       clk;
    logic       RST_N;
    logic [3:0] SW;
    logic       KEY_ENTER_N;
    logic       KEY_CLEAR_N;
    logic [9:0] VALUE;
    logic       OVF;
    logic       ERR;
    logic       FULL;
    logic       BUSY;
`ifdef DEC_ENTRY_ECHO_EN
    logic [6:0] HEX3, HEX2, HEX1, HEX0;
`endif

    int errors = 0;
    int checks = 0;
    int bc;
    int seen;

    dec_entry_accum #(
        .MAX_DIGITS (4),
        .OUT_W      (10)
    ) dut (
        .CLOCK_50    (clk),
        .RST_N       (RST_N),
        .SW          (SW),
        .KEY_ENTER_N (KEY_ENTER_N),
        .KEY_CLEAR_N (KEY_CLEAR_N),
        .VALUE       (VALUE),
        .OVF         (OVF),
        .ERR         (ERR),
        .FULL        (FULL),
        .BUSY        (BUSY)
`ifdef DEC_ENTRY_ECHO_EN
        ,
        .HEX3        (HEX3),
        .HEX2        (HEX2),
        .HEX1        (HEX1),
        .HEX0        (HEX0)
`endif
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Press enter with digit d; return number of cycles BUSY was high.
    task automatic enter_digit(input logic [3:0] d, output int nb);
        int n;
        nb = 0;
        @(negedge clk);
        SW = d;
        KEY_ENTER_N = 1'b0;
        @(negedge clk);
        @(negedge clk);
        KEY_ENTER_N = 1'b1;
        n = 0;
        while (!BUSY && n < 12) begin
            @(negedge clk);
            n++;
        end
        while (BUSY && nb < 12) begin
            nb++;
            @(negedge clk);
        end
    endtask

    // Press enter and report whether BUSY was ever seen.
    task automatic press_only(input logic [3:0] d, output int b);
        b = 0;
        @(negedge clk);
        SW = d;
        KEY_ENTER_N = 1'b0;
        @(negedge clk);
        @(negedge clk);
        KEY_ENTER_N = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (BUSY) b = 1;
        end
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        KEY_CLEAR_N = 1'b0;
        @(negedge clk);
        @(negedge clk);
        KEY_CLEAR_N = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        SW = 4'd0;
        KEY_ENTER_N = 1'b1;
        KEY_CLEAR_N = 1'b1;
        RST_N = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_value", 32'(VALUE), 0);
        check("rst_ovf", 32'(OVF), 0);
        check("rst_err", 32'(ERR), 0);
        check("rst_full", 32'(FULL), 0);
        check("rst_busy", 32'(BUSY), 0);
`ifdef DEC_ENTRY_ECHO_EN
        check("rst_hex0", 32'(HEX0), 32'h7f);
        check("rst_hex3", 32'(HEX3), 32'h7f);
`endif
        RST_N = 1'b1;
        repeat (2) @(negedge clk);

        enter_digit(4'd1, bc);
        check("busy_d1", bc, 3);
        enter_digit(4'd2, bc);
        check("busy_d2", bc, 3);
        enter_digit(4'd3, bc);
        check("busy_d3", bc, 3);
        check("val_123", 32'(VALUE), 123);
        check("cnt_3", 32'(dut.cnt), 3);
        check("ovf_123", 32'(OVF), 0);
        check("full_123", 32'(FULL), 0);

        pulse_clear();
        check("clr_value", 32'(VALUE), 0);
        for (int i = 0; i < 4; i++) begin
            enter_digit(4'd9, bc);
            check("busy_9", bc, 3);
        end
        check("val_9999", 32'(VALUE), 783);
        check("acc_9999", 32'(dut.acc), 9999);
        check("ovf_9999", 32'(OVF), 1);
        check("full_9999", 32'(FULL), 1);
        press_only(4'd5, seen);
        check("fifth_busy", seen, 0);
        check("fifth_val", 32'(VALUE), 783);
        check("fifth_full", 32'(FULL), 1);
        check("fifth_err", 32'(ERR), 0);
        check("fifth_ovf", 32'(OVF), 1);

        pulse_clear();
        enter_digit(4'd4, bc);
        press_only(4'd12, seen);
        check("bad_busy", seen, 0);
        check("bad_err", 32'(ERR), 1);
        check("bad_val", 32'(VALUE), 4);
        enter_digit(4'd7, bc);
        check("val_47", 32'(VALUE), 47);
        check("err_sticky", 32'(ERR), 1);

        // Clear lands during MUL8 of the second digit.
        pulse_clear();
        check("clr_err", 32'(ERR), 0);
        enter_digit(4'd5, bc);
        press_only(4'd13, seen);
        check("pre_err", 32'(ERR), 1);
        @(negedge clk);
        SW = 4'd6;
        KEY_ENTER_N = 1'b0;
        @(negedge clk);
        KEY_CLEAR_N = 1'b0;
        seen = 0;
        for (int n = 0; n < 12; n++) begin
            if (!BUSY) @(negedge clk);
        end
        check("mid_busy_seen", 32'(BUSY), 1);
        check("mid_state", 32'(dut.state), 1);
        @(negedge clk);
        check("mid_busy", 32'(BUSY), 0);
        check("mid_val", 32'(VALUE), 0);
        check("mid_err", 32'(ERR), 0);
        check("mid_cnt", 32'(dut.cnt), 0);
        KEY_ENTER_N = 1'b1;
        KEY_CLEAR_N = 1'b1;
        repeat (8) @(negedge clk);
        check("mid_after", 32'(VALUE), 0);

        // Second press two cycles later is dropped.
        pulse_clear();
        @(negedge clk);
        SW = 4'd6;
        KEY_ENTER_N = 1'b0;
        @(negedge clk);
        KEY_ENTER_N = 1'b1;
        @(negedge clk);
        KEY_ENTER_N = 1'b0;
        @(negedge clk);
        KEY_ENTER_N = 1'b1;
        repeat (14) @(negedge clk);
        check("dbl_val", 32'(VALUE), 6);
        check("dbl_cnt", 32'(dut.cnt), 1);

        // Simultaneous enter and clear: clear wins.
        @(negedge clk);
        SW = 4'd3;
        KEY_ENTER_N = 1'b0;
        KEY_CLEAR_N = 1'b0;
        @(negedge clk);
        @(negedge clk);
        KEY_ENTER_N = 1'b1;
        KEY_CLEAR_N = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (BUSY) seen = 1;
        end
        check("sim_busy", seen, 0);
        check("sim_val", 32'(VALUE), 0);
        check("sim_cnt", 32'(dut.cnt), 0);

        enter_digit(4'd4, bc);
        enter_digit(4'd2, bc);
        check("val_42", 32'(VALUE), 42);
`ifdef DEC_ENTRY_ECHO_EN
        check("hex0_2", 32'(HEX0), 32'(7'b0100100));
        check("hex1_4", 32'(HEX1), 32'(7'b0011001));
        check("hex2_blank", 32'(HEX2), 32'h7f);
        check("hex3_blank", 32'(HEX3), 32'h7f);
`endif

        // Asynchronous reset between clock edges.
        @(negedge clk);
        #3;
        RST_N = 1'b0;
        #1;
        check("arst_val", 32'(VALUE), 0);
        check("arst_cnt", 32'(dut.cnt), 0);
`ifdef DEC_ENTRY_ECHO_EN
        check("arst_hex0", 32'(HEX0), 32'h7f);
        check("arst_hex1", 32'(HEX1), 32'h7f);
`endif
        @(negedge clk);
        RST_N = 1'b1;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
